// File: rtl/arb_m2_rr_if.sv
// arb_m2_rr_if: req/ack/resp memory bus; master drives requests, slave returns ack and read responses
interface arb_m2_rr_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;
  modport master (output req, we, addr, wdata, be, input ack, resp, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, resp, rdata);
endinterface

// File: rtl/arb_m2_rr.sv
// arb_m2_rr: two-master round-robin arbiter onto one slave, routing in-order read responses to the issuing master
module arb_m2_rr #(
  parameter int MAX_RD = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  arb_m2_rr_if.slave  m0,
  arb_m2_rr_if.slave  m1,
  arb_m2_rr_if.master s
);
  localparam int CW = $clog2(MAX_RD + 1);
  logic          rr_last, lock_vld, lock_id, rd_own;
  logic [CW-1:0] rd_cnt;
  logic          idle, rd_room, el0, el1, hold, gnt_vld, gnt_id, rd_acc, rd_dec, rsp0, rsp1;
  // Only the read owner may issue while reads are outstanding; its writes bypass the read limit
  assign idle    = rd_cnt == '0;
  assign rd_room = rd_cnt < CW'(MAX_RD);
  assign el0     = m0.req & (idle | (!rd_own & (m0.we | rd_room)));
  assign el1     = m1.req & (idle | (rd_own & (m1.we | rd_room)));
  assign hold    = lock_vld & (lock_id ? el1 : el0);
  assign gnt_vld = rst_i & (el0 | el1);
  assign gnt_id  = hold ? lock_id : (el0 & el1) ? !rr_last : el1;
  assign s.req   = gnt_vld;
  assign s.we    = gnt_vld & (gnt_id ? m1.we : m0.we);
  assign s.addr  = gnt_vld ? (gnt_id ? m1.addr : m0.addr) : '0;
  assign s.wdata = gnt_vld ? (gnt_id ? m1.wdata : m0.wdata) : '0;
  assign s.be    = gnt_vld ? (gnt_id ? m1.be : m0.be) : '0;
  assign m0.ack  = gnt_vld & !gnt_id & s.ack;
  assign m1.ack  = gnt_vld & gnt_id & s.ack;
  assign rsp0     = rst_i & !idle & !rd_own;
  assign rsp1     = rst_i & !idle & rd_own;
  assign m0.resp  = rsp0 & s.resp;
  assign m1.resp  = rsp1 & s.resp;
  assign m0.rdata = rsp0 ? s.rdata : '0;
  assign m1.rdata = rsp1 ? s.rdata : '0;
  assign rd_acc = gnt_vld & !s.we & s.ack;
  assign rd_dec = s.resp & !idle;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_last  <= 1'b1;
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
      rd_own   <= 1'b0;
      rd_cnt   <= '0;
    end else begin
      lock_vld <= gnt_vld & !s.ack;
      if (gnt_vld) lock_id <= gnt_id;
      if (gnt_vld & s.ack) rr_last <= gnt_id;
      if (rd_acc) rd_own <= gnt_id;
      rd_cnt <= (rd_acc == rd_dec) ? rd_cnt : rd_acc ? rd_cnt + 1'b1 : rd_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_arb_m2_rr.sv
// tb_arb_m2_rr: scoreboard bench for the two-master round-robin arbiter
module tb_arb_m2_rr;
  typedef struct {logic id; logic [31:0] data;} rd_t;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int checks = 0;
  int failures = 0;
  logic last_g = 1'b1;
  rd_t rdq[$];
  logic gq[$];
  arb_m2_rr_if m0_if();
  arb_m2_rr_if m1_if();
  arb_m2_rr_if s_if();
  arb_m2_rr #(.MAX_RD(4)) dut (.clk_i(clk_i), .rst_i(rst_i), .m0(m0_if), .m1(m1_if), .s(s_if));
  always #5 clk_i = ~clk_i;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic idle_in();
    m0_if.req = 0; m0_if.we = 0; m0_if.addr = 0; m0_if.wdata = 0; m0_if.be = 0;
    m1_if.req = 0; m1_if.we = 0; m1_if.addr = 0; m1_if.wdata = 0; m1_if.be = 0;
    s_if.ack = 0; s_if.resp = 0; s_if.rdata = 0;
  endtask
  task automatic drv(input logic r0, w0, input logic [31:0] a0, input logic r1, w1,
                     input logic [31:0] a1, input logic ack, rsp, input logic [31:0] rd);
    @(negedge clk_i);
    m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = ~a0; m0_if.be = 4'hf;
    m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = ~a1; m1_if.be = 4'h3;
    s_if.ack = ack; s_if.resp = rsp; s_if.rdata = rd;
    #1;
  endtask
  task automatic test_reset();
    rst_i = 1'b0;
    drv(1, 1, 32'h10, 1, 1, 32'h20, 1, 1, 32'h1234);
    checks++; if (s_if.req !== 1'b0) begin failures++; $display("FAIL rst_sreq: got %0h expected 0", s_if.req); end
    checks++; if (s_if.addr !== 32'h0) begin failures++; $display("FAIL rst_saddr: got %0h expected 0", s_if.addr); end
    checks++; if ({m0_if.ack, m1_if.ack} !== 2'b00) begin failures++; $display("FAIL rst_ack: got %0b expected 00", {m0_if.ack, m1_if.ack}); end
    checks++; if ({m0_if.resp, m1_if.resp} !== 2'b00) begin failures++; $display("FAIL rst_resp: got %0b expected 00", {m0_if.resp, m1_if.resp}); end
    checks++; if (m0_if.rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %0h expected 0", m0_if.rdata); end
    checks++; if (int'(dut.rd_cnt) != 0) begin failures++; $display("FAIL rst_rdcnt: got %0d expected 0", dut.rd_cnt); end
    idle_in();
    rst_i = 1'b1;
    last_g = 1'b1;
  endtask
  task automatic test_rr_writes();
    logic g;
    for (int k = 0; k < 6; k++) begin
      gq.push_back(!last_g);
      last_g = !last_g;
      drv(1, 1, 32'h1000 + k, 1, 1, 32'h2000 + k, 1, 0, 0);
      g = gq.pop_front();
      checks++; if (s_if.addr !== (g ? 32'h2000 + k : 32'h1000 + k)) begin failures++; $display("FAIL rr_addr[%0d]: got %0h expected %0h", k, s_if.addr, g ? 32'h2000 + k : 32'h1000 + k); end
      checks++; if ({m1_if.ack, m0_if.ack} !== (g ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_ack[%0d]: got %0b expected %0b", k, {m1_if.ack, m0_if.ack}, g ? 2'b10 : 2'b01); end
      checks++; if (s_if.wdata !== ~(g ? 32'h2000 + k : 32'h1000 + k)) begin failures++; $display("FAIL rr_wdata[%0d]: got %0h expected %0h", k, s_if.wdata, ~(g ? 32'h2000 + k : 32'h1000 + k)); end
    end
  endtask
  task automatic test_read_block();
    rd_t e;
    drv(1, 0, 32'h100, 0, 0, 0, 1, 0, 0);
    checks++; if (m0_if.ack !== 1'b1 || s_if.we !== 1'b0) begin failures++; $display("FAIL rb_accept: got ack=%0b we=%0b expected ack=1 we=0", m0_if.ack, s_if.we); end
    rdq.push_back('{1'b0, 32'hDEADBEEF});
    last_g = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drv(0, 0, 0, 1, 1, 32'h200, 1, 0, 0);
      checks++; if (m1_if.ack !== 1'b0 || s_if.req !== 1'b0) begin failures++; $display("FAIL rb_m1_blocked[%0d]: got ack=%0b sreq=%0b expected 0 0", k, m1_if.ack, s_if.req); end
    end
    drv(0, 0, 0, 1, 1, 32'h200, 1, 1, rdq[0].data);
    e = rdq.pop_front();
    checks++; if (m0_if.resp !== 1'b1 || m0_if.rdata !== e.data) begin failures++; $display("FAIL rb_resp: got resp=%0b rdata=%0h expected resp=1 rdata=%0h", m0_if.resp, m0_if.rdata, e.data); end
    checks++; if (m1_if.ack !== 1'b0 || m1_if.resp !== 1'b0) begin failures++; $display("FAIL rb_m1_quiet: got ack=%0b resp=%0b expected 0 0", m1_if.ack, m1_if.resp); end
    drv(0, 0, 0, 1, 1, 32'h200, 1, 0, 0);
    checks++; if (m1_if.ack !== 1'b1 || s_if.addr !== 32'h200) begin failures++; $display("FAIL rb_m1_grant: got ack=%0b addr=%0h expected ack=1 addr=200", m1_if.ack, s_if.addr); end
    last_g = 1'b1;
  endtask
  task automatic test_max_rd();
    rd_t e;
    for (int k = 0; k < 5; k++) begin
      drv(1, 0, 32'h300 + 4 * k, 0, 0, 0, 1, 0, 0);
      if (k < 4) begin
        checks++; if (m0_if.ack !== 1'b1) begin failures++; $display("FAIL mx_read_ack[%0d]: got %0b expected 1", k, m0_if.ack); end
        rdq.push_back('{1'b0, 32'hA000_0000 + k});
        last_g = 1'b0;
      end else begin
        checks++; if (m0_if.ack !== 1'b0 || s_if.req !== 1'b0) begin failures++; $display("FAIL mx_fifth_held: got ack=%0b sreq=%0b expected 0 0", m0_if.ack, s_if.req); end
      end
    end
    drv(1, 1, 32'h400, 0, 0, 0, 1, 0, 0);
    checks++; if (m0_if.ack !== 1'b1 || s_if.we !== 1'b1) begin failures++; $display("FAIL mx_write_pass: got ack=%0b we=%0b expected 1 1", m0_if.ack, s_if.we); end
    drv(1, 0, 32'h310, 0, 0, 0, 1, 1, rdq[0].data);
    e = rdq.pop_front();
    checks++; if (m0_if.ack !== 1'b0) begin failures++; $display("FAIL mx_held_at_resp: got %0b expected 0", m0_if.ack); end
    checks++; if (m0_if.resp !== 1'b1 || m0_if.rdata !== e.data) begin failures++; $display("FAIL mx_resp: got resp=%0b rdata=%0h expected 1 %0h", m0_if.resp, m0_if.rdata, e.data); end
    drv(1, 0, 32'h310, 0, 0, 0, 1, 0, 0);
    checks++; if (m0_if.ack !== 1'b1) begin failures++; $display("FAIL mx_released: got %0b expected 1", m0_if.ack); end
    rdq.push_back('{1'b0, 32'hA000_0004});
    while (rdq.size() > 0) begin
      drv(0, 0, 0, 0, 0, 0, 0, 1, rdq[0].data);
      e = rdq.pop_front();
      checks++; if (m0_if.resp !== 1'b1 || m0_if.rdata !== e.data || m1_if.resp !== 1'b0) begin failures++; $display("FAIL mx_drain: got resp=%0b rdata=%0h m1resp=%0b expected 1 %0h 0", m0_if.resp, m0_if.rdata, m1_if.resp, e.data); end
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (int'(dut.rd_cnt) != rdq.size()) begin failures++; $display("FAIL mx_cnt: got %0d expected %0d", dut.rd_cnt, rdq.size()); end
  endtask
  task automatic test_lock();
    logic g;
    g = !last_g;
    for (int k = 0; k < 3; k++) begin
      drv(1, 1, 32'h500, 1, 1, 32'h600, 0, 0, 0);
      checks++; if (s_if.addr !== (g ? 32'h600 : 32'h500) || {m1_if.ack, m0_if.ack} !== 2'b00) begin failures++; $display("FAIL lk_hold[%0d]: got addr=%0h ack=%0b expected %0h 00", k, s_if.addr, {m1_if.ack, m0_if.ack}, g ? 32'h600 : 32'h500); end
    end
    drv(1, 1, 32'h500, 1, 1, 32'h600, 1, 0, 0);
    checks++; if (s_if.addr !== (g ? 32'h600 : 32'h500) || {m1_if.ack, m0_if.ack} !== (g ? 2'b10 : 2'b01)) begin failures++; $display("FAIL lk_ack: got addr=%0h ack=%0b", s_if.addr, {m1_if.ack, m0_if.ack}); end
    last_g = g;
    g = !last_g;
    drv(1, 1, 32'h500, 1, 1, 32'h600, 1, 0, 0);
    checks++; if (s_if.addr !== (g ? 32'h600 : 32'h500) || {m1_if.ack, m0_if.ack} !== (g ? 2'b10 : 2'b01)) begin failures++; $display("FAIL lk_next: got addr=%0h ack=%0b", s_if.addr, {m1_if.ack, m0_if.ack}); end
    last_g = g;
  endtask
  task automatic test_same_cycle();
    rd_t e;
    for (int k = 0; k < 2; k++) begin
      drv(1, 0, 32'h700 + 4 * k, 0, 0, 0, 1, 0, 0);
      checks++; if (m0_if.ack !== 1'b1) begin failures++; $display("FAIL sc_read[%0d]: got %0b expected 1", k, m0_if.ack); end
      rdq.push_back('{1'b0, 32'hB000_0000 + k});
    end
    last_g = 1'b0;
    drv(1, 0, 32'h708, 0, 0, 0, 1, 1, rdq[0].data);
    e = rdq.pop_front();
    checks++; if (m0_if.ack !== 1'b1 || m0_if.resp !== 1'b1 || m0_if.rdata !== e.data) begin failures++; $display("FAIL sc_both: got ack=%0b resp=%0b rdata=%0h expected 1 1 %0h", m0_if.ack, m0_if.resp, m0_if.rdata, e.data); end
    rdq.push_back('{1'b0, 32'hB000_0002});
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (int'(dut.rd_cnt) != rdq.size()) begin failures++; $display("FAIL sc_cnt: got %0d expected %0d", dut.rd_cnt, rdq.size()); end
    while (rdq.size() > 0) begin
      drv(0, 0, 0, 0, 0, 0, 0, 1, rdq[0].data);
      e = rdq.pop_front();
      checks++; if (m0_if.resp !== 1'b1 || m0_if.rdata !== e.data) begin failures++; $display("FAIL sc_drain: got resp=%0b rdata=%0h expected 1 %0h", m0_if.resp, m0_if.rdata, e.data); end
    end
    drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    checks++; if ({m0_if.resp, m1_if.resp} !== 2'b00 || m0_if.rdata !== 32'h0 || m1_if.rdata !== 32'h0) begin failures++; $display("FAIL sc_spurious: got resp=%0b rdata0=%0h rdata1=%0h expected 00 0 0", {m0_if.resp, m1_if.resp}, m0_if.rdata, m1_if.rdata); end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (int'(dut.rd_cnt) != 0) begin failures++; $display("FAIL sc_no_underflow: got %0d expected 0", dut.rd_cnt); end
  endtask
  task automatic test_reset_mid();
    rd_t e;
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 0, 1, 0, 32'h800 + 4 * k, 1, 0, 0);
      checks++; if (m1_if.ack !== 1'b1) begin failures++; $display("FAIL rm_read[%0d]: got %0b expected 1", k, m1_if.ack); end
      rdq.push_back('{1'b1, 32'hC000_0000 + k});
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (int'(dut.rd_cnt) != rdq.size()) begin failures++; $display("FAIL rm_cnt: got %0d expected %0d", dut.rd_cnt, rdq.size()); end
    rst_i = 1'b0;
    drv(1, 0, 32'h900, 1, 0, 32'h904, 1, 1, 32'h5A5A_5A5A);
    checks++; if (s_if.req !== 1'b0 || {m1_if.ack, m0_if.ack} !== 2'b00) begin failures++; $display("FAIL rm_gated: got sreq=%0b ack=%0b expected 0 00", s_if.req, {m1_if.ack, m0_if.ack}); end
    checks++; if (m1_if.resp !== 1'b0 || m1_if.rdata !== 32'h0) begin failures++; $display("FAIL rm_resp_gated: got resp=%0b rdata=%0h expected 0 0", m1_if.resp, m1_if.rdata); end
    rdq.delete();
    idle_in();
    rst_i = 1'b1;
    last_g = 1'b1;
    drv(0, 0, 0, 1, 0, 32'h900, 1, 1, 32'hBAD0_BAD0);
    checks++; if (m1_if.ack !== 1'b1 || m1_if.resp !== 1'b0) begin failures++; $display("FAIL rm_fresh: got ack=%0b resp=%0b expected 1 0", m1_if.ack, m1_if.resp); end
    rdq.push_back('{1'b1, 32'hCAFE_F00D});
    drv(0, 0, 0, 0, 0, 0, 0, 1, rdq[0].data);
    e = rdq.pop_front();
    checks++; if (m1_if.resp !== 1'b1 || m1_if.rdata !== e.data || m0_if.resp !== 1'b0) begin failures++; $display("FAIL rm_route: got resp=%0b rdata=%0h m0resp=%0b expected 1 %0h 0", m1_if.resp, m1_if.rdata, m0_if.resp, e.data); end
  endtask
  initial begin
    idle_in();
    test_reset();
    test_rr_writes();
    test_read_block();
    test_max_rd();
    test_lock();
    test_same_cycle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
